// File: rtl/cal_adder_9_int8_pkg.sv
// Shared CNN datapath constants and the signed saturation helper used by the
// 3x3 window adder tree.
package cnn_pkg;

  localparam int PROD_W   = 16;
  localparam int SUM9_W   = 18;
  localparam int ADD9_LAT = 4;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int                 width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/cal_adder_9_int8_if.sv
// Window bus between the 3x3 multiplier array and the adder tree: nine
// products in, one saturated sum out.
interface cal_adder_9_int8_if #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 18
) ();

  logic                     valid_in;
  logic signed [DIN_W-1:0]  a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic signed [DOUT_W-1:0] dout;
  logic                     valid_out;
  logic                     ovf;

  modport master (
    output valid_in, a0, a1, a2, a3, a4, a5, a6, a7, a8,
    input  dout, valid_out, ovf
  );

  modport slave (
    input  valid_in, a0, a1, a2, a3, a4, a5, a6, a7, a8,
    output dout, valid_out, ovf
  );

endinterface

// File: rtl/cal_adder_9_int8_add_pair_reg.sv
// One registered adder node of the tree: full-precision signed a+b, one bit
// wider than the operands so no node can overflow.
module add_pair_reg #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   sum
);

  // Sign-extended sum register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= {(W + 1){1'b0}};
    end else begin
      sum <= {a[W-1], a} + {b[W-1], b};
    end
  end

endmodule

// File: rtl/cal_adder_9_int8.sv
// Four-stage pipelined adder tree summing one 3x3 window of signed products,
// with a saturating (or wrapping) output stage and a matching valid pipe.
module cal_adder_9_int8
  import cnn_pkg::*;
#(
  parameter int DIN_W    = PROD_W,
  parameter int DOUT_W   = SUM9_W,
  parameter int SATURATE = 1
) (
  input logic                clk,
  input logic                rst_n,
  cal_adder_9_int8_if.slave  bus
);

  logic signed [DIN_W-1:0]  a_s [0:8];
  logic signed [DIN_W:0]    p_r [0:3];
  logic signed [DIN_W:0]    p4_r;
  logic signed [DIN_W+1:0]  q_r [0:1];
  logic signed [DIN_W+1:0]  q2_r;
  logic signed [DIN_W+2:0]  r0_r;
  logic signed [DIN_W+2:0]  r1_r;
  logic signed [DIN_W+3:0]  s_s;
  logic signed [31:0]       s_ext_s;
  logic signed [31:0]       sat_s;
  logic signed [DOUT_W-1:0] dout_s;
  logic                     ovf_s;
  logic signed [DOUT_W-1:0] dout_r;
  logic                     ovf_r;
  logic [ADD9_LAT-1:0]      vld_r;

  assign a_s[0] = bus.a0;
  assign a_s[1] = bus.a1;
  assign a_s[2] = bus.a2;
  assign a_s[3] = bus.a3;
  assign a_s[4] = bus.a4;
  assign a_s[5] = bus.a5;
  assign a_s[6] = bus.a6;
  assign a_s[7] = bus.a7;
  assign a_s[8] = bus.a8;

  // Stage 1: four pair sums of row-major neighbours, a8 rides alongside.
  for (genvar i = 0; i < 4; i++) begin : g_s1
    add_pair_reg #(.W(DIN_W)) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a_s[2*i]),
      .b     (a_s[2*i+1]),
      .sum   (p_r[i])
    );
  end

  // Stage 2 and 3 adder nodes.
  for (genvar j = 0; j < 2; j++) begin : g_s2
    add_pair_reg #(.W(DIN_W + 1)) u_add (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (p_r[2*j]),
      .b     (p_r[2*j+1]),
      .sum   (q_r[j])
    );
  end

  add_pair_reg #(.W(DIN_W + 2)) u_s3 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (q_r[0]),
    .b     (q_r[1]),
    .sum   (r0_r)
  );

  // Pass-through lane for the odd ninth product, widened each stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p4_r <= {(DIN_W + 1){1'b0}};
      q2_r <= {(DIN_W + 2){1'b0}};
      r1_r <= {(DIN_W + 3){1'b0}};
    end else begin
      p4_r <= {a_s[8][DIN_W-1], a_s[8]};
      q2_r <= {p4_r[DIN_W], p4_r};
      r1_r <= {q2_r[DIN_W+1], q2_r};
    end
  end

  // Final sum and range check; ovf reports range exceed even in wrap mode.
  always_comb begin
    s_s     = {r0_r[DIN_W+2], r0_r} + {r1_r[DIN_W+2], r1_r};
    s_ext_s = 32'(s_s);
    sat_s   = sat_signed(s_ext_s, DOUT_W);
    ovf_s   = (sat_s != s_ext_s);
    if (SATURATE != 0) begin
      dout_s = sat_s[DOUT_W-1:0];
    end else begin
      dout_s = s_s[DOUT_W-1:0];
    end
  end

  // Stage 4 output register and valid pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r <= {DOUT_W{1'b0}};
      ovf_r  <= 1'b0;
      vld_r  <= {ADD9_LAT{1'b0}};
    end else begin
      dout_r <= dout_s;
      ovf_r  <= ovf_s;
      vld_r  <= {vld_r[ADD9_LAT-2:0], bus.valid_in};
    end
  end

  assign bus.dout      = dout_r;
  assign bus.ovf       = ovf_r;
  assign bus.valid_out = vld_r[ADD9_LAT-1];

endmodule

// File: tb/tb_cal_adder_9_int8.sv
// Self-checking bench for the 3x3 window adder tree: directed windows with
// hand-computed sums plus a long random stream against a sum-and-clamp model.
module tb_cal_adder_9_int8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  bit   started;

  cal_adder_9_int8_if #(.DIN_W(16), .DOUT_W(18)) bus ();

  cal_adder_9_int8 #(.DIN_W(16), .DOUT_W(18), .SATURATE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the window sum and validity seen at each of the last four edges.
  int sum_h [4];
  bit vld_h [4];

  function automatic int window_sum();
    return int'(bus.a0) + int'(bus.a1) + int'(bus.a2) + int'(bus.a3) + int'(bus.a4)
         + int'(bus.a5) + int'(bus.a6) + int'(bus.a7) + int'(bus.a8);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sum_h[i] <= 0;
        vld_h[i] <= 1'b0;
      end
    end else begin
      sum_h[0] <= window_sum();
      vld_h[0] <= bus.valid_in;
      for (int i = 1; i < 4; i++) begin
        sum_h[i] <= sum_h[i-1];
        vld_h[i] <= vld_h[i-1];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      int e;
      int e_sat;
      e     = sum_h[3];
      e_sat = (e > 131071) ? 131071 : ((e < -131072) ? -131072 : e);
      chk("model_dout", int'(bus.dout), e_sat);
      chk("model_ovf", int'(bus.ovf), (e_sat != e) ? 1 : 0);
      chk("model_valid", int'(bus.valid_out), int'(vld_h[3]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v [9], input bit vld);
    bus.a0 = 16'(v[0]); bus.a1 = 16'(v[1]); bus.a2 = 16'(v[2]);
    bus.a3 = 16'(v[3]); bus.a4 = 16'(v[4]); bus.a5 = 16'(v[5]);
    bus.a6 = 16'(v[6]); bus.a7 = 16'(v[7]); bus.a8 = 16'(v[8]);
    bus.valid_in = vld;
  endtask

  task automatic drive_zero();
    int z [9];
    for (int i = 0; i < 9; i++) z[i] = 0;
    drive(z, 1'b0);
  endtask

  // One isolated window: result must appear exactly 4 edges later for one cycle.
  task automatic directed(input string nm, input int v [9], input int exp_d, input int exp_o);
    drive(v, 1'b1);
    step();
    drive_zero();
    repeat (3) step();
    chk({nm, "_dout"}, int'(bus.dout), exp_d);
    chk({nm, "_ovf"}, int'(bus.ovf), exp_o);
    chk({nm, "_valid"}, int'(bus.valid_out), 1);
    step();
    chk({nm, "_valid_drop"}, int'(bus.valid_out), 0);
  endtask

  function automatic int rprod();
    return ($urandom_range(0, 255) - 128) * ($urandom_range(0, 255) - 128);
  endfunction

  task automatic rand_vec(output int v [9]);
    int mode;
    mode = $urandom_range(0, 15);
    for (int i = 0; i < 9; i++) begin
      if (mode == 0)      v[i] = 16384;
      else if (mode == 1) v[i] = -16256;
      else if (mode == 2) v[i] = ($urandom_range(0, 1) == 0) ? 16384 : 16129;
      else                v[i] = rprod();
    end
  endtask

  initial begin
    int v [9];
    n_tests = 0;
    n_fail  = 0;
    started = 1'b0;
    rst_n   = 1'b0;
    drive_zero();

    @(posedge clk);
    started = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("rst_dout", int'(bus.dout), 0);
      chk("rst_valid", int'(bus.valid_out), 0);
      chk("rst_ovf", int'(bus.ovf), 0);
      step();
    end
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", int'(bus.valid_out), 0);
    chk("post_rst_dout", int'(bus.dout), 0);

    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    directed("seq45", v, 45, 0);
    for (int i = 0; i < 9; i++) v[i] = 16384;
    directed("pos_sat", v, 131071, 1);
    for (int i = 0; i < 9; i++) v[i] = -16256;
    directed("neg_sat", v, -131072, 1);
    v = '{100, -200, 300, -400, 500, -600, 700, -800, 900};
    directed("mixed", v, 500, 0);

    for (int k = 0; k < 1200; k++) begin
      rand_vec(v);
      drive(v, 1'b1);
      step();
    end

    rand_vec(v);
    drive(v, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_valid", int'(bus.valid_out), 0);
    chk("midrst_ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;
    drive_zero();
    repeat (2) step();

    for (int k = 0; k < 1200; k++) begin
      rand_vec(v);
      drive(v, 1'b1);
      step();
      if (k < 4) chk("resume_valid", int'(bus.valid_out), (k == 3) ? 1 : 0);
    end

    drive_zero();
    repeat (6) step();
    chk("drain_valid", int'(bus.valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
